// File: rtl/truth_table_sweeper_if.sv
// Signal bundle between a sweep controller and the truth-table sweeper.
// The sweeper takes the slave side; whoever requests sweeps and supplies F takes the master side.
interface truth_table_sweeper_if;
   logic        start;
   logic        f_in;
   logic        a;
   logic        b;
   logic        c;
   logic        d;
   logic        busy;
   logic        done;
   logic [15:0] truth;
   logic [4:0]  ones_count;

   modport master (
      output start, f_in,
      input  a, b, c, d, busy, done, truth, ones_count
   );

   modport slave (
      input  start, f_in,
      output a, b, c, d, busy, done, truth, ones_count
   );
endinterface

// File: rtl/truth_table_sweeper.sv
// Drives all 16 {A,B,C,D} vectors for HOLD clocks each.
// Captures F at the end of each hold into a truth table plus a ones count.
module truth_table_sweeper #(
   parameter int unsigned HOLD = 20
) (
   input  logic                   clk,
   input  logic                   rst_n,
   truth_table_sweeper_if.slave   sw
);

   typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

   localparam logic [15:0] HOLD_LAST = 16'(HOLD - 1);

   state_t      state_q, state_d;
   logic [3:0]  vec_q, vec_d;
   logic [15:0] cnt_q, cnt_d;
   logic [15:0] truth_q, truth_d;
   logic [4:0]  ones_q, ones_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         vec_q   <= '0;
         cnt_q   <= '0;
         truth_q <= '0;
         ones_q  <= '0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         cnt_q   <= cnt_d;
         truth_q <= truth_d;
         ones_q  <= ones_d;
      end
   end

   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      cnt_d   = cnt_q;
      truth_d = truth_q;
      ones_d  = ones_q;
      case (state_q)
         IDLE, DONE: begin
            // DONE falls straight into a new sweep when start is held.
            if (sw.start) begin
               state_d = SWEEP;
               vec_d   = '0;
               cnt_d   = '0;
               truth_d = '0;
               ones_d  = '0;
            end else begin
               state_d = IDLE;
            end
         end
         SWEEP: begin
            if (cnt_q == HOLD_LAST) begin
               truth_d[vec_q] = sw.f_in;
               ones_d         = ones_q + {4'b0, sw.f_in};
               cnt_d          = '0;
               vec_d          = vec_q + 4'd1;
               if (vec_q == 4'hF) state_d = DONE;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign sw.a          = vec_q[3];
   assign sw.b          = vec_q[2];
   assign sw.c          = vec_q[1];
   assign sw.d          = vec_q[0];
   assign sw.busy       = (state_q == SWEEP);
   assign sw.done       = (state_q == DONE);
   assign sw.truth      = truth_q;
   assign sw.ones_count = ones_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: a HOLD=20 and a HOLD=1 instance fed by a shared behavioural F.
module tb_truth_table_sweeper;

   localparam int F_ZERO = 0, F_ONE = 1, F_AND = 2, F_XOR = 3, F_A = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   truth_table_sweeper_if if20 ();
   truth_table_sweeper_if if1 ();

   truth_table_sweeper #(.HOLD(20)) dut20 (.clk(clk), .rst_n(rst_n), .sw(if20.slave));
   truth_table_sweeper #(.HOLD(1))  dut1  (.clk(clk), .rst_n(rst_n), .sw(if1.slave));

   int   fsel;
   logic sel1;

   function automatic logic fn(input int s, input logic [3:0] v);
      case (s)
         F_ONE:   return 1'b1;
         F_AND:   return v[3] & v[2];
         F_XOR:   return ^v;
         F_A:     return v[3];
         default: return 1'b0;
      endcase
   endfunction

   assign if20.f_in = fn(fsel, {if20.a, if20.b, if20.c, if20.d});
   assign if1.f_in  = fn(fsel, {if1.a, if1.b, if1.c, if1.d});

   logic [3:0]  m_vec;
   logic        m_busy, m_done;
   logic [15:0] m_truth;
   logic [4:0]  m_ones;
   assign m_vec   = sel1 ? {if1.a, if1.b, if1.c, if1.d} : {if20.a, if20.b, if20.c, if20.d};
   assign m_busy  = sel1 ? if1.busy  : if20.busy;
   assign m_done  = sel1 ? if1.done  : if20.done;
   assign m_truth = sel1 ? if1.truth : if20.truth;
   assign m_ones  = sel1 ? if1.ones_count : if20.ones_count;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic set_start(input logic v);
      if (sel1) if1.start = v;
      else      if20.start = v;
   endtask

   typedef struct {
      logic        use1;
      int          f;
      logic [15:0] exp_truth;
      logic [4:0]  exp_ones;
   } vec_t;

   // Start a sweep with a one-cycle pulse and watch it to completion.
   task automatic run_sweep(input logic use1, input int f, input logic [15:0] et,
                            input logic [4:0] eo, input string tag);
      int h, busy_cnt, order_err, done_edge;
      bit seen;
      sel1 = use1;
      h = use1 ? 1 : 20;
      fsel = f;
      busy_cnt = 0; order_err = 0; done_edge = -1; seen = 0;
      @(negedge clk);
      set_start(1'b1);
      for (int i = 1; i <= 16 * h + 10; i++) begin
         @(negedge clk);
         set_start(1'b0);
         if (m_busy) begin
            busy_cnt++;
            if (m_vec != 4'((i - 1) / h)) order_err++;
         end
         if (m_done) begin
            done_edge = i - 1;
            seen = 1;
            break;
         end
      end
      chk({tag, "_done_seen"}, 32'(seen), 32'd1);
      chk({tag, "_done_edge"}, 32'(done_edge), 32'(16 * h));
      chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(16 * h));
      chk({tag, "_vec_order"}, 32'(order_err), 32'd0);
      chk({tag, "_truth"}, 32'(m_truth), 32'(et));
      chk({tag, "_ones"}, 32'(m_ones), 32'(eo));
      @(negedge clk);
      chk({tag, "_done_width"}, 32'(m_done), 32'd0);
      chk({tag, "_abcd_after"}, 32'(m_vec), 32'd0);
      chk({tag, "_truth_held"}, 32'(m_truth), 32'(et));
   endtask

   vec_t tbl[7];

   initial begin
      int dones, busy_cnt;
      tbl[0] = '{1'b0, F_AND,  16'hF000, 5'd4};
      tbl[1] = '{1'b0, F_XOR,  16'h6996, 5'd8};
      tbl[2] = '{1'b1, F_ONE,  16'hFFFF, 5'd16};
      tbl[3] = '{1'b1, F_XOR,  16'h6996, 5'd8};
      tbl[4] = '{1'b1, F_ZERO, 16'h0000, 5'd0};
      tbl[5] = '{1'b1, F_AND,  16'hF000, 5'd4};
      tbl[6] = '{1'b0, F_A,    16'hFF00, 5'd8};

      // Reset held with start asserted must not launch a sweep.
      sel1 = 1'b0; fsel = F_ONE;
      rst_n = 1'b0; if20.start = 1'b1; if1.start = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy20", 32'(if20.busy), 32'd0);
      chk("rst_busy1", 32'(if1.busy), 32'd0);
      chk("rst_done", 32'({if20.done, if1.done}), 32'd0);
      chk("rst_abcd", 32'({if20.a, if20.b, if20.c, if20.d, if1.a, if1.b, if1.c, if1.d}), 32'd0);
      chk("rst_truth", 32'({if20.truth, if1.truth}), 32'd0);
      chk("rst_ones", 32'({if20.ones_count, if1.ones_count}), 32'd0);
      if20.start = 1'b0; if1.start = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_after_rst", 32'({if20.busy, if1.busy}), 32'd0);

      foreach (tbl[k])
         run_sweep(tbl[k].use1, tbl[k].f, tbl[k].exp_truth, tbl[k].exp_ones,
                   $sformatf("v%0d", k));

      // start re-pulsed at vector 5 is ignored: one sweep, one done pulse.
      sel1 = 1'b0; fsel = F_AND; dones = 0; busy_cnt = 0;
      @(negedge clk); if20.start = 1'b1;
      @(negedge clk); if20.start = 1'b0;
      if (if20.busy) busy_cnt++;
      for (int i = 0; i < 400; i++) begin
         if ({if20.a, if20.b, if20.c, if20.d} == 4'd5 && i < 120) if20.start = 1'b1;
         else if20.start = 1'b0;
         @(negedge clk);
         if (if20.busy) busy_cnt++;
         if (if20.done) dones++;
      end
      if20.start = 1'b0;
      chk("repulse_dones", 32'(dones), 32'd1);
      chk("repulse_busy", 32'(busy_cnt), 32'd320);
      chk("repulse_truth", 32'(if20.truth), 32'hF000);

      // Mid-sweep reset at vector 9 aborts with no done pulse.
      fsel = F_ONE; dones = 0;
      @(negedge clk); if20.start = 1'b1;
      @(negedge clk); if20.start = 1'b0;
      for (int i = 0; i < 400 && {if20.a, if20.b, if20.c, if20.d} != 4'd9; i++)
         @(negedge clk);
      chk("mid_reached_vec9", 32'({if20.a, if20.b, if20.c, if20.d}), 32'd9);
      chk("mid_truth_before", 32'(if20.truth), 32'h01FF);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_busy", 32'(if20.busy), 32'd0);
      chk("mid_truth", 32'(if20.truth), 32'd0);
      chk("mid_ones", 32'(if20.ones_count), 32'd0);
      chk("mid_abcd", 32'({if20.a, if20.b, if20.c, if20.d}), 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (if20.done || if20.busy) dones++;
      end
      chk("mid_no_done", 32'(dones), 32'd0);

      // Start held through DONE gives back-to-back sweeps.
      fsel = F_A;
      @(negedge clk); if20.start = 1'b1;
      for (int i = 0; i < 400 && !if20.done; i++) @(negedge clk);
      chk("b2b_first_done", 32'(if20.done), 32'd1);
      chk("b2b_first_truth", 32'(if20.truth), 32'hFF00);
      @(negedge clk);
      if20.start = 1'b0;
      chk("b2b_restart_busy", 32'(if20.busy), 32'd1);
      chk("b2b_restart_truth", 32'(if20.truth), 32'd0);
      chk("b2b_restart_ones", 32'(if20.ones_count), 32'd0);
      for (int i = 0; i < 400 && !if20.done; i++) @(negedge clk);
      chk("b2b_second_done", 32'(if20.done), 32'd1);
      chk("b2b_second_truth", 32'(if20.truth), 32'hFF00);
      chk("b2b_second_ones", 32'(if20.ones_count), 32'd8);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
